// File: rtl/grey_dec_4b_0101.sv
// ---------------------------------------------------------------------------
// grey_dec_4b_0101
//
// Purpose:
//   Decodes a 4-bit Gray-coded position sequence whose index 0 is the code
//   0101, tracks the step direction between consecutive samples, flags
//   illegal jumps, and reports lock once LOCK_N consecutive legal up/down
//   steps have been seen. Latency is one clock from an accepted sample to
//   the registered outputs.
//
//   The index is idx = (gray_to_binary(g) + 10) mod 16, so
//   0101 -> 0, 0100 -> 1, 1100 -> 2, ..., 0111 -> 15.
//   Index steps are taken modulo 16, so 15 -> 0 counts as up and 0 -> 15
//   counts as down.
//
// Optional feature:
//   GREY_DEC_POS_EN  - when defined, pos is an 8-bit up/down position
//                      accumulator (+1 per up step, -1 per down step, mod
//                      256). When undefined, pos is tied to zero and no
//                      accumulator exists.
//
// Parameters:
//   LOCK_N     - consecutive legal steps needed to enter lock (1..15).
//
// Ports:
//   clk        in   1  rising-edge clock, the only clock
//   rst_n      in   1  synchronous, active-low reset
//   in_valid   in   1  g holds a sample this cycle
//   g          in   4  Gray-coded sample
//   idx        out  4  decoded sequence index (registered)
//   out_valid  out  1  one-cycle pulse: idx/dir/step_err updated
//   dir        out  1  direction of the last legal step (1 = up)
//   step_err   out  1  one-cycle pulse: illegal transition
//   err_cnt    out  8  saturating illegal-transition count
//   locked     out  1  high exactly while the tracker is in LOCK
//   pos        out  8  position accumulator (zero unless GREY_DEC_POS_EN)
// ---------------------------------------------------------------------------
module grey_dec_4b_0101 #(
  parameter int LOCK_N = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [3:0] g,
  output logic [3:0] idx,
  output logic       out_valid,
  output logic       dir,
  output logic       step_err,
  output logic [7:0] err_cnt,
  output logic       locked,
  output logic [7:0] pos
);

  // IDLE: no previous sample; ACQ: counting good steps; LOCK: tracking.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACQ  = 2'd1,
    LOCK = 2'd2
  } state_t;

  // Wide enough to compare cnt_reg + 1 against LOCK_N = 15 without wrap.
  localparam logic [4:0] LOCK_TARGET = 5'(LOCK_N);

  state_t     state_reg, state_next;
  logic [3:0] idx_reg, idx_next;
  logic       out_valid_reg, out_valid_next;
  logic       dir_reg, dir_next;
  logic       step_err_reg, step_err_next;
  logic [7:0] err_cnt_reg, err_cnt_next;
  logic [3:0] cnt_reg, cnt_next;

  // -------------------------------------------------------------------------
  // Decode. Each binary bit is the XOR of all Gray bits at or above it; this
  // is written per bit so there is no bit-to-bit combinational chain.
  // -------------------------------------------------------------------------
  logic [3:0] bin_dec;
  logic [3:0] idx_new;

  for (genvar gi = 0; gi < 4; gi++) begin : g_gray2bin
    assign bin_dec[gi] = ^g[3:gi];
  end

  // Offset so that 0101 (binary 6) lands on index 0; 4-bit wrap is mod 16.
  assign idx_new = bin_dec + 4'd10;

  // -------------------------------------------------------------------------
  // Step classification against the previously accepted index. idx_reg
  // always holds the last accepted sample, so it doubles as idx_prev.
  // -------------------------------------------------------------------------
  logic [3:0] delta;
  logic       is_hold;
  logic       is_up;
  logic       is_dn;
  logic       tracking;
  logic       take_up;
  logic       take_dn;
  logic [4:0] cnt_inc;

  assign delta    = idx_new - idx_reg;
  assign is_hold  = (delta == 4'd0);
  assign is_up    = (delta == 4'd1);
  assign is_dn    = (delta == 4'd15);
  assign tracking = (state_reg != IDLE);
  assign take_up  = in_valid && tracking && is_up;
  assign take_dn  = in_valid && tracking && is_dn;
  assign cnt_inc  = {1'b0, cnt_reg} + 5'd1;

  // -------------------------------------------------------------------------
  // Next-state and next-output logic.
  // -------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    out_valid_next = 1'b0;
    dir_next       = dir_reg;
    step_err_next  = 1'b0;
    err_cnt_next   = err_cnt_reg;
    cnt_next       = cnt_reg;

    if (in_valid) begin
      idx_next       = idx_new;
      out_valid_next = 1'b1;

      if (!tracking) begin
        // First sample only establishes the reference; no step is judged.
        state_next = ACQ;
        cnt_next   = 4'd0;
      end else if (take_up || take_dn) begin
        dir_next = take_up;
        // Once locked the counter has done its job and is left alone.
        if (state_reg == ACQ) begin
          cnt_next = cnt_inc[3:0];
          if (cnt_inc >= LOCK_TARGET) begin
            state_next = LOCK;
          end
        end
      end else if (!is_hold) begin
        // Illegal jump: restart acquisition from this sample, keep dir.
        step_err_next = 1'b1;
        cnt_next      = 4'd0;
        state_next    = ACQ;
        if (err_cnt_reg != 8'hFF) begin
          err_cnt_next = err_cnt_reg + 8'd1;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // State and output registers. A sample presented while rst_n is low is
  // simply dropped, so the next accepted sample starts again from IDLE.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      idx_reg       <= 4'd0;
      out_valid_reg <= 1'b0;
      dir_reg       <= 1'b1;
      step_err_reg  <= 1'b0;
      err_cnt_reg   <= 8'd0;
      cnt_reg       <= 4'd0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      out_valid_reg <= out_valid_next;
      dir_reg       <= dir_next;
      step_err_reg  <= step_err_next;
      err_cnt_reg   <= err_cnt_next;
      cnt_reg       <= cnt_next;
    end
  end

  assign idx       = idx_reg;
  assign out_valid = out_valid_reg;
  assign dir       = dir_reg;
  assign step_err  = step_err_reg;
  assign err_cnt   = err_cnt_reg;
  assign locked    = (state_reg == LOCK);

  // -------------------------------------------------------------------------
  // Optional position accumulator. Holds and illegal samples leave it alone
  // because only legal up/down steps drive take_up/take_dn.
  // -------------------------------------------------------------------------
`ifdef GREY_DEC_POS_EN
  logic [7:0] pos_reg, pos_next;

  always_comb begin
    pos_next = pos_reg;
    if (take_up) begin
      pos_next = pos_reg + 8'd1;
    end else if (take_dn) begin
      pos_next = pos_reg - 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pos_reg <= 8'd0;
    end else begin
      pos_reg <= pos_next;
    end
  end

  assign pos = pos_reg;
`else
  assign pos = 8'd0;
`endif

endmodule

// File: tb/tb_grey_dec_4b_0101.sv
// ---------------------------------------------------------------------------
// tb_grey_dec_4b_0101
//
// Self-checking bench for grey_dec_4b_0101 (LOCK_N = 2). A behavioural
// model tracks the expected outputs from the decode/step rules using plain
// integer arithmetic; directed scenarios also check literal values.
// Honours GREY_DEC_POS_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_grey_dec_4b_0101;

  localparam int LOCK_N = 2;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] g;
  logic [3:0] idx;
  logic       out_valid;
  logic       dir;
  logic       step_err;
  logic [7:0] err_cnt;
  logic       locked;
  logic [7:0] pos;

  int checks;
  int failures;
  int txn;

  // Model state: mode 0 = no previous sample, 1 = acquiring, 2 = locked.
  int         m_mode;
  int         m_cnt;
  int         m_err;
  int         m_pos;
  logic [3:0] exp_idx;
  logic       exp_ov;
  logic       exp_dir;
  logic       exp_serr;

  grey_dec_4b_0101 #(.LOCK_N(LOCK_N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .g         (g),
    .idx       (idx),
    .out_valid (out_valid),
    .dir       (dir),
    .step_err  (step_err),
    .err_cnt   (err_cnt),
    .locked    (locked),
    .pos       (pos)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int gray_to_idx(input logic [3:0] gv);
    int x;
    int b;
    x = int'(gv);
    b = x ^ (x >> 1) ^ (x >> 2) ^ (x >> 3);
    return (b + 10) % 16;
  endfunction

  function automatic logic [3:0] idx_to_gray(input int i);
    int b;
    b = (i + 6) % 16;
    return 4'(b ^ (b >> 1));
  endfunction

  function automatic logic exp_locked();
    return (m_mode == 2);
  endfunction

  function automatic logic [7:0] exp_err();
    return 8'(m_err);
  endfunction

  function automatic logic [7:0] exp_pos();
`ifdef GREY_DEC_POS_EN
    return 8'(m_pos);
`else
    return 8'd0;
`endif
  endfunction

  // Apply one cycle of inputs, advance the model at the clock edge, and
  // leave the bench 1 ns after the edge where outputs are sampled.
  task automatic tick(input logic r, input logic v, input logic [3:0] gv);
    int nidx;
    int d;
    rst_n    = r;
    in_valid = v;
    g        = gv;
    @(posedge clk);
    if (!r) begin
      m_mode = 0; m_cnt = 0; m_err = 0; m_pos = 0;
      exp_idx = 4'd0; exp_ov = 1'b0; exp_dir = 1'b1; exp_serr = 1'b0;
    end else begin
      exp_ov   = 1'b0;
      exp_serr = 1'b0;
      if (v) begin
        nidx   = gray_to_idx(gv);
        exp_ov = 1'b1;
        if (m_mode == 0) begin
          m_mode = 1;
          m_cnt  = 0;
        end else begin
          d = (nidx - int'(exp_idx) + 16) % 16;
          if (d == 1 || d == 15) begin
            exp_dir = (d == 1);
            m_pos   = (m_pos + ((d == 1) ? 1 : 255)) % 256;
            if (m_mode == 1) begin
              m_cnt++;
              if (m_cnt >= LOCK_N) m_mode = 2;
            end
          end else if (d != 0) begin
            exp_serr = 1'b1;
            if (m_err < 255) m_err++;
            m_cnt  = 0;
            m_mode = 1;
          end
        end
        exp_idx = 4'(nidx);
      end
    end
    #1;
    txn++;
    $display("txn %0d rst_n=%0b in_valid=%0b g=%b -> idx=%0d ov=%0b dir=%0b serr=%0b err=%0d lock=%0b pos=%0d",
             txn, r, v, gv, idx, out_valid, dir, step_err, err_cnt, locked, pos);
  endtask

  task automatic test_reset();
    tick(1'b0, 1'b1, 4'($urandom_range(0, 15)));
    tick(1'b0, 1'b1, 4'($urandom_range(0, 15)));
    checks++; if (idx !== 4'd0) begin failures++; $display("FAIL reset_idx got=%0d want=0", idx); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_ov got=%b want=0", out_valid); end
    checks++; if (dir !== 1'b1) begin failures++; $display("FAIL reset_dir got=%b want=1", dir); end
    checks++; if (step_err !== 1'b0) begin failures++; $display("FAIL reset_serr got=%b want=0", step_err); end
    checks++; if (err_cnt !== 8'd0) begin failures++; $display("FAIL reset_err got=%0d want=0", err_cnt); end
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL reset_locked got=%b want=0", locked); end
    checks++; if (pos !== 8'd0) begin failures++; $display("FAIL reset_pos got=%0d want=0", pos); end
  endtask

  task automatic test_lock_seq();
    logic [3:0] seq [3];
    seq[0] = 4'b0101; seq[1] = 4'b0100; seq[2] = 4'b1100;
    tick(1'b0, 1'b0, 4'd0);
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b1, seq[i]);
      checks++; if (idx !== 4'(i)) begin failures++; $display("FAIL lock_seq_idx%0d got=%0d want=%0d", i, idx, i); end
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL lock_seq_ov%0d got=%b want=1", i, out_valid); end
      checks++; if (locked !== (i == 2)) begin failures++; $display("FAIL lock_seq_locked%0d got=%b want=%b", i, locked, (i == 2)); end
    end
    checks++; if (dir !== 1'b1) begin failures++; $display("FAIL lock_seq_dir got=%b want=1", dir); end
  endtask

  task automatic test_wrap();
    tick(1'b0, 1'b0, 4'd0);
    tick(1'b1, 1'b1, 4'b0111);
    checks++; if (idx !== 4'd15) begin failures++; $display("FAIL wrap_idx15 got=%0d want=15", idx); end
    tick(1'b1, 1'b1, 4'b0101);
    checks++; if (idx !== 4'd0) begin failures++; $display("FAIL wrap_idx0 got=%0d want=0", idx); end
    checks++; if (step_err !== 1'b0) begin failures++; $display("FAIL wrap_up_serr got=%b want=0", step_err); end
    checks++; if (dir !== 1'b1) begin failures++; $display("FAIL wrap_up_dir got=%b want=1", dir); end
    tick(1'b0, 1'b0, 4'd0);
    tick(1'b1, 1'b1, 4'b0101);
    tick(1'b1, 1'b1, 4'b0111);
    checks++; if (step_err !== 1'b0) begin failures++; $display("FAIL wrap_dn_serr got=%b want=0", step_err); end
    checks++; if (dir !== 1'b0) begin failures++; $display("FAIL wrap_dn_dir got=%b want=0", dir); end
  endtask

  task automatic test_illegal();
    tick(1'b0, 1'b0, 4'd0);
    tick(1'b1, 1'b1, 4'b0101);
    tick(1'b1, 1'b1, 4'b0100);
    tick(1'b1, 1'b1, 4'b1100);
    tick(1'b1, 1'b1, 4'b1101);
    checks++; if (idx !== 4'd3 || locked !== 1'b1) begin failures++; $display("FAIL illegal_pre idx=%0d locked=%b want idx=3 locked=1", idx, locked); end
    tick(1'b1, 1'b1, 4'b0000);
    checks++; if (step_err !== 1'b1) begin failures++; $display("FAIL illegal_serr got=%b want=1", step_err); end
    checks++; if (err_cnt !== 8'd1) begin failures++; $display("FAIL illegal_errcnt got=%0d want=1", err_cnt); end
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL illegal_locked got=%b want=0", locked); end
    checks++; if (idx !== 4'd10) begin failures++; $display("FAIL illegal_idx got=%0d want=10", idx); end
    checks++; if (dir !== 1'b1) begin failures++; $display("FAIL illegal_dir got=%b want=1", dir); end
    tick(1'b1, 1'b0, 4'd0);
    checks++; if (step_err !== 1'b0) begin failures++; $display("FAIL illegal_pulse got=%b want=0", step_err); end
    // Back in ACQ from idx 10: two more up steps are needed to relock.
    tick(1'b1, 1'b1, 4'b0001);
    checks++; if (locked !== 1'b0 || step_err !== 1'b0) begin failures++; $display("FAIL illegal_acq1 locked=%b serr=%b want 0 0", locked, step_err); end
    tick(1'b1, 1'b1, 4'b0011);
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL illegal_relock got=%b want=1", locked); end
  endtask

  task automatic test_saturate();
    tick(1'b0, 1'b0, 4'd0);
    for (int i = 0; i < 300; i++) begin
      tick(1'b1, 1'b1, (i % 2 == 0) ? 4'b0101 : 4'b1111);
      checks++; if (err_cnt !== exp_err()) begin failures++; $display("FAIL sat_errcnt%0d got=%0d want=%0d", i, err_cnt, exp_err()); end
    end
    checks++; if (err_cnt !== 8'd255) begin failures++; $display("FAIL sat_final got=%0d want=255", err_cnt); end
    checks++; if (step_err !== 1'b1) begin failures++; $display("FAIL sat_serr got=%b want=1", step_err); end
  endtask

  task automatic test_hold();
    tick(1'b0, 1'b0, 4'd0);
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 1'b1, 4'b1100);
      checks++; if (out_valid !== 1'b1 || idx !== 4'd2) begin failures++; $display("FAIL hold%0d ov=%b idx=%0d want ov=1 idx=2", i, out_valid, idx); end
      checks++; if (step_err !== 1'b0 || locked !== 1'b0) begin failures++; $display("FAIL hold_state%0d serr=%b locked=%b want 0 0", i, step_err, locked); end
    end
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b0, 4'($urandom_range(0, 15)));
      checks++; if (out_valid !== 1'b0 || idx !== 4'd2) begin failures++; $display("FAIL gap%0d ov=%b idx=%0d want ov=0 idx=2", i, out_valid, idx); end
    end
    // A single up step after the holds must not lock: holds did not count.
    tick(1'b1, 1'b1, 4'b1101);
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL hold_nocount got=%b want=0", locked); end
  endtask

  task automatic test_pos_and_midreset();
    logic [7:0] want;
    tick(1'b0, 1'b0, 4'd0);
    tick(1'b1, 1'b1, idx_to_gray(5));
    for (int i = 1; i <= 3; i++) tick(1'b1, 1'b1, idx_to_gray(5 + i));
    for (int i = 1; i <= 5; i++) tick(1'b1, 1'b1, idx_to_gray(8 - i));
`ifdef GREY_DEC_POS_EN
    want = 8'd254;
`else
    want = 8'd0;
`endif
    checks++; if (pos !== want) begin failures++; $display("FAIL pos_updown got=%0d want=%0d", pos, want); end
    checks++; if (dir !== 1'b0) begin failures++; $display("FAIL pos_dir got=%b want=0", dir); end
    tick(1'b0, 1'b1, idx_to_gray(2));
    checks++; if (idx !== 4'd0 || out_valid !== 1'b0 || dir !== 1'b1 || locked !== 1'b0 || pos !== 8'd0 || err_cnt !== 8'd0)
      begin failures++; $display("FAIL midreset idx=%0d ov=%b dir=%b lock=%b pos=%0d err=%0d", idx, out_valid, dir, locked, pos, err_cnt); end
    // First sample after reset is a fresh reference: far jump, no error.
    tick(1'b1, 1'b1, 4'b0000);
    checks++; if (step_err !== 1'b0 || idx !== 4'd10 || out_valid !== 1'b1) begin failures++; $display("FAIL post_reset serr=%b idx=%0d ov=%b want 0 10 1", step_err, idx, out_valid); end
  endtask

  task automatic test_random();
    int cur;
    int sel;
    logic r;
    logic v;
    logic [3:0] gv;
    tick(1'b0, 1'b0, 4'd0);
    cur = 0;
    for (int i = 0; i < 500; i++) begin
      r   = ($urandom_range(0, 59) != 0);
      v   = ($urandom_range(0, 3) != 0);
      sel = $urandom_range(0, 9);
      if (sel < 2)      cur = cur;
      else if (sel < 5) cur = (cur + 1) % 16;
      else if (sel < 8) cur = (cur + 15) % 16;
      else              cur = $urandom_range(0, 15);
      gv = idx_to_gray(cur);
      tick(r, v, gv);
      checks++; if (idx !== exp_idx) begin failures++; $display("FAIL rnd_idx%0d got=%0d want=%0d", i, idx, exp_idx); end
      checks++; if (out_valid !== exp_ov) begin failures++; $display("FAIL rnd_ov%0d got=%b want=%b", i, out_valid, exp_ov); end
      checks++; if (dir !== exp_dir) begin failures++; $display("FAIL rnd_dir%0d got=%b want=%b", i, dir, exp_dir); end
      checks++; if (step_err !== exp_serr) begin failures++; $display("FAIL rnd_serr%0d got=%b want=%b", i, step_err, exp_serr); end
      checks++; if (err_cnt !== exp_err()) begin failures++; $display("FAIL rnd_err%0d got=%0d want=%0d", i, err_cnt, exp_err()); end
      checks++; if (locked !== exp_locked()) begin failures++; $display("FAIL rnd_locked%0d got=%b want=%b", i, locked, exp_locked()); end
      checks++; if (pos !== exp_pos()) begin failures++; $display("FAIL rnd_pos%0d got=%0d want=%0d", i, pos, exp_pos()); end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    txn      = 0;
    m_mode = 0; m_cnt = 0; m_err = 0; m_pos = 0;
    exp_idx = 4'd0; exp_ov = 1'b0; exp_dir = 1'b1; exp_serr = 1'b0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    g        = 4'd0;
    @(negedge clk);

    test_reset();
    test_lock_seq();
    test_wrap();
    test_illegal();
    test_saturate();
    test_hold();
    test_pos_and_midreset();
    test_random();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/grey_dec_4b_0101.md
GREY_DEC_4B_0101 -- requirements
Module: grey_dec_4b_0101

Interface
REQ-001 SHALL have parameter LOCK_N, default 2, meaning the number of consecutive legal steps needed to assert locked (range 1..15).
REQ-002 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-003 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-004 SHALL have port in_valid  input  1  g holds a sample this cycle.
REQ-005 SHALL have port g  input  4  Gray-coded sample from the 0101-start sequence.
REQ-006 SHALL have port idx  output  4  decoded sequence index.
REQ-007 SHALL have port out_valid  output  1  one-cycle pulse: idx/dir/step_err updated.
REQ-008 SHALL have port dir  output  1  last step direction (1 = up).
REQ-009 SHALL have port step_err  output  1  one-cycle pulse: illegal transition.
REQ-010 SHALL have port err_cnt  output  8  saturating illegal-transition count.
REQ-011 SHALL have port locked  output  1  tracking is locked.
REQ-012 SHALL have port pos  output  8  position accumulator (see Configuration).

Function
REQ-013 SHALL decode as follows: b = standard Gray-to-binary of g; idx = (b + 10) mod 16 (0101->0, 0100->1, 1100->2, ... 0111->15).
REQ-014 SHALL have latency 1: a sample accepted at edge N gives idx/out_valid at edge N+1; out_valid SHALL be low in cycles without in_valid.
REQ-015 SHALL implement states IDLE (no previous sample), ACQ (counting good steps) and LOCK.
REQ-016 SHALL compute, for each sample in ACQ/LOCK, d = (idx_new - idx_prev) mod 16 and act as follows: d=0 hold (dir unchanged, no error); d=1 up (dir=1); d=15 down (dir=0); any other d is illegal.
REQ-017 SHALL move IDLE->ACQ on the first valid sample, with no step evaluated and the step counter at 0.
REQ-018 SHALL, in ACQ, increment the step counter on each legal d=1/15 step and enter LOCK when the counter reaches LOCK_N; d=0 SHALL neither count nor clear.
REQ-019 SHALL, on an illegal d in ACQ or LOCK: pulse step_err with out_valid; saturate err_cnt at 255; clear the step counter; go to ACQ; deassert locked; take the new sample as idx_prev; leave dir unchanged.
REQ-020 SHALL treat the 15->0 wrap as an up step and the 0->15 wrap as a down step.
REQ-021 SHALL drive locked high exactly while in state LOCK.
REQ-022 SHALL update idx_prev on every accepted sample.

Reset
REQ-023 SHALL, while rst_n=0 at a clk edge, set state IDLE, idx=0, out_valid=0, dir=1, step_err=0, err_cnt=0, locked=0, pos=0 and step counter=0.
REQ-024 SHALL, when reset is applied mid-stream, discard the in-flight sample, and SHALL treat the first sample after reset as an IDLE first sample.

Configuration
REQ-025 SHALL, with GREY_DEC_POS_EN defined, make pos an 8-bit accumulator with +1 per up step and -1 per down step (mod 256), registered with the same latency as idx and unchanged on hold or illegal samples.
REQ-026 SHALL, with GREY_DEC_POS_EN undefined, tie pos to 0 and synthesise no accumulator logic.

Verification
REQ-027 SHALL cover: reset, then g=0101,0100,1100 on consecutive cycles -> idx 0,1,2 one cycle later, dir=1, locked=1 after the third sample (LOCK_N=2).
REQ-028 SHALL cover: g=0111 then 0101 -> idx 15 then 0, treated as an up step, no step_err; reverse order -> dir=0.
REQ-029 SHALL cover: locked at idx 3 (1101), then g=0000 (idx 10) -> step_err=1 for 1 cycle, err_cnt=1, locked=0, state ACQ.
REQ-030 SHALL cover: 300 illegal jumps alternating g=0101/1111 -> err_cnt saturates at 255, no wrap.
REQ-031 SHALL cover: the same g repeated 5 cycles -> out_valid each cycle, idx constant, no count, no error; in_valid=0 gaps -> out_valid=0.
REQ-032 SHALL cover: with GREY_DEC_POS_EN, 3 up steps then 5 down steps -> pos=254; rst_n=0 mid-stream -> all outputs at reset values next cycle.
